// File: rtl/ir_line_position.sv
// ir_line_position: weighted-average line position from eight QTRX
// time-to-decay readings. A start request snapshots the readings, removes
// the ambient floor, accumulates one channel per clock, then runs a
// 16-step restoring divider to produce position = wsum / sum.
module ir_line_position #(
    parameter int                TTD_W       = 17,
    parameter logic [TTD_W-1:0]  FLOOR       = 17'd3200,
    parameter int                WEIGHT_STEP = 1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [7:0]       channel_sel,
    input  logic [TTD_W-1:0] ttd0,
    input  logic [TTD_W-1:0] ttd1,
    input  logic [TTD_W-1:0] ttd2,
    input  logic [TTD_W-1:0] ttd3,
    input  logic [TTD_W-1:0] ttd4,
    input  logic [TTD_W-1:0] ttd5,
    input  logic [TTD_W-1:0] ttd6,
    input  logic [TTD_W-1:0] ttd7,
    output logic             busy,
    output logic             valid,
    output logic [15:0]      position,
    output logic             line_lost
);

    // Datapath widths: sum holds 8 full-scale readings, weights reach
    // 7*WEIGHT_STEP, wsum holds sum*max_weight, and the divider remainder
    // needs one bit more than the divisor to hold the shifted partial value.
    localparam int SUM_W  = TTD_W + 3;
    localparam int WGT_W  = 13;
    localparam int WSUM_W = TTD_W + 16;
    localparam int REM_W  = SUM_W + 1;
    localparam int Q_W    = 16;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_CHECK,
        S_DIV
    } state_t;

    state_t state_reg, state_next;

    logic [TTD_W-1:0]  ttd_in   [8];
    logic [TTD_W-1:0]  snap_reg [8];
    logic [7:0]        sel_reg;
    logic              snap_en;

    logic [2:0]        idx_reg, idx_next;
    logic [SUM_W-1:0]  sum_reg, sum_next;
    logic [WSUM_W-1:0] wsum_reg, wsum_next;

    logic [REM_W-1:0]  rem_reg, rem_next;
    logic [Q_W-1:0]    dvd_lo_reg, dvd_lo_next;
    logic [Q_W-1:0]    quot_reg, quot_next;
    logic [3:0]        iter_reg, iter_next;

    logic [15:0]       position_reg, position_next;
    logic              line_lost_reg, line_lost_next;
    logic              valid_reg, valid_next;

    logic [TTD_W-1:0]  cond_v     [8];
    logic [WGT_W-1:0]  weight_tab [8];
    logic [TTD_W-1:0]  cur_v;
    logic [WGT_W-1:0]  cur_w;
    logic [WSUM_W-1:0] cur_prod;

    logic [REM_W-1:0]  div_shift;
    logic [REM_W-1:0]  div_diff;
    logic              div_ge;

    assign ttd_in[0] = ttd0;
    assign ttd_in[1] = ttd1;
    assign ttd_in[2] = ttd2;
    assign ttd_in[3] = ttd3;
    assign ttd_in[4] = ttd4;
    assign ttd_in[5] = ttd5;
    assign ttd_in[6] = ttd6;
    assign ttd_in[7] = ttd7;

    // Per-channel conditioning (mask, floor removal clamped at zero) and
    // the constant weight table, indexed by the accumulate counter below.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_ch
            assign cond_v[gi]     = (sel_reg[gi] && (snap_reg[gi] > FLOOR))
                                    ? (snap_reg[gi] - FLOOR) : '0;
            assign weight_tab[gi] = WGT_W'(gi * WEIGHT_STEP);
        end
    endgenerate

    assign cur_v    = cond_v[idx_reg];
    assign cur_w    = weight_tab[idx_reg];
    assign cur_prod = WSUM_W'(cur_v) * WSUM_W'(cur_w);

    // One restoring step: shift in the next dividend bit, subtract divisor if it fits.
    assign div_shift = {rem_reg[REM_W-2:0], dvd_lo_reg[Q_W-1]};
    assign div_ge    = (div_shift >= REM_W'(sum_reg));
    assign div_diff  = div_shift - REM_W'(sum_reg);

    assign busy      = (state_reg != S_IDLE);
    assign valid     = valid_reg;
    assign position  = position_reg;
    assign line_lost = line_lost_reg;

    // Next-state and datapath control; every target defaults to holding.
    always_comb begin
        state_next     = state_reg;
        snap_en        = 1'b0;
        idx_next       = idx_reg;
        sum_next       = sum_reg;
        wsum_next      = wsum_reg;
        rem_next       = rem_reg;
        dvd_lo_next    = dvd_lo_reg;
        quot_next      = quot_reg;
        iter_next      = iter_reg;
        position_next  = position_reg;
        line_lost_next = line_lost_reg;
        valid_next     = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    snap_en    = 1'b1;
                    sum_next   = '0;
                    wsum_next  = '0;
                    idx_next   = 3'd0;
                    state_next = S_ACCUM;
                end
            end
            S_ACCUM: begin
                sum_next  = sum_reg + SUM_W'(cur_v);
                wsum_next = wsum_reg + cur_prod;
                idx_next  = idx_reg + 3'd1;
                if (idx_reg == 3'd7) begin
                    state_next = S_CHECK;
                end
            end
            S_CHECK: begin
                if (sum_reg == '0) begin
                    line_lost_next = 1'b1;
                    valid_next     = 1'b1;
                    state_next     = S_IDLE;
                end else begin
                    // Quotient <= 7*WEIGHT_STEP < 2^16, so the upper dividend
                    // bits are already below the divisor and seed the remainder.
                    rem_next    = REM_W'(wsum_reg[WSUM_W-1:Q_W]);
                    dvd_lo_next = wsum_reg[Q_W-1:0];
                    quot_next   = '0;
                    iter_next   = 4'd0;
                    state_next  = S_DIV;
                end
            end
            S_DIV: begin
                rem_next    = div_ge ? div_diff : div_shift;
                dvd_lo_next = {dvd_lo_reg[Q_W-2:0], 1'b0};
                quot_next   = {quot_reg[Q_W-2:0], div_ge};
                iter_next   = iter_reg + 4'd1;
                if (iter_reg == 4'd15) begin
                    position_next  = {quot_reg[Q_W-2:0], div_ge};
                    line_lost_next = 1'b0;
                    valid_next     = 1'b1;
                    state_next     = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // State, snapshot, accumulator, divider and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= S_IDLE;
            sel_reg       <= '0;
            idx_reg       <= '0;
            sum_reg       <= '0;
            wsum_reg      <= '0;
            rem_reg       <= '0;
            dvd_lo_reg    <= '0;
            quot_reg      <= '0;
            iter_reg      <= '0;
            position_reg  <= '0;
            line_lost_reg <= 1'b0;
            valid_reg     <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                snap_reg[i] <= '0;
            end
        end else begin
            state_reg     <= state_next;
            idx_reg       <= idx_next;
            sum_reg       <= sum_next;
            wsum_reg      <= wsum_next;
            rem_reg       <= rem_next;
            dvd_lo_reg    <= dvd_lo_next;
            quot_reg      <= quot_next;
            iter_reg      <= iter_next;
            position_reg  <= position_next;
            line_lost_reg <= line_lost_next;
            valid_reg     <= valid_next;
            if (snap_en) begin
                sel_reg <= channel_sel;
                for (int i = 0; i < 8; i++) begin
                    snap_reg[i] <= ttd_in[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_ir_line_position.sv
// Testbench for ir_line_position: scoreboard of expected results pushed at
// each start and popped when valid pulses.
module tb_ir_line_position;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  channel_sel;
    logic [16:0] ttd_a [8];
    logic        busy;
    logic        valid;
    logic [15:0] position;
    logic        line_lost;

    always #5 clk = ~clk;

    ir_line_position dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .channel_sel (channel_sel),
        .ttd0        (ttd_a[0]),
        .ttd1        (ttd_a[1]),
        .ttd2        (ttd_a[2]),
        .ttd3        (ttd_a[3]),
        .ttd4        (ttd_a[4]),
        .ttd5        (ttd_a[5]),
        .ttd6        (ttd_a[6]),
        .ttd7        (ttd_a[7]),
        .busy        (busy),
        .valid       (valid),
        .position    (position),
        .line_lost   (line_lost)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] pos;
        logic        lost;
        int          due;
        int          busy_len;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   mpos  = 0;
    int   e0    = 0;

    // Reference: floor removal, mask, weighted sum, truncated division.
    task automatic model(input logic [16:0] t[8], input logic [7:0] sel,
                         output logic [15:0] pos, output logic lost);
        longint sum  = 0;
        longint wsum = 0;
        longint v;
        for (int i = 0; i < 8; i++) begin
            v = (sel[i] && t[i] > 17'd3200) ? longint'(t[i]) - 3200 : 0;
            sum  += v;
            wsum += v * i * 1000;
        end
        if (sum == 0) begin
            lost = 1'b1;
            pos  = 16'(mpos);
        end else begin
            lost = 1'b0;
            pos  = 16'(wsum / sum);
            mpos = int'(wsum / sum);
        end
    endtask

    // Drive inputs and start at the current negedge; push the expectation.
    task automatic launch(input string name, input logic [16:0] t[8], input logic [7:0] sel);
        exp_t e;
        model(t, sel, e.pos, e.lost);
        e.busy_len = e.lost ? 9 : 25;
        e.due      = cyc + 1 + e.busy_len;
        e.name     = name;
        sb.push_back(e);
        for (int i = 0; i < 8; i++) ttd_a[i] = t[i];
        channel_sel = sel;
        start       = 1'b1;
        e0          = cyc + 1;
    endtask

    // Wait for the next valid pulse, compare it with the scoreboard head.
    // hold keeps start high; inj pulses start at that negedge cycle; scramble
    // disturbs the inputs right after the start has been sampled.
    task automatic wait_result(input bit hold, input int inj, input bit scramble);
        int   busy_cnt = 0;
        bit   seen     = 1'b0;
        exp_t e;
        for (int n = 0; n < 60 && !seen; n++) begin
            @(negedge clk);
            if (!hold) start = (cyc == inj);
            if (scramble && n == 0) begin
                for (int i = 0; i < 8; i++) ttd_a[i] = 17'($urandom);
                channel_sel = 8'($urandom);
            end
            if (busy) busy_cnt++;
            if (valid) begin
                seen = 1'b1;
                if (sb.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_valid: cycle=%0d with empty scoreboard", cyc);
                end else begin
                    e = sb.pop_front();
                    total++;
                    if (position !== e.pos) begin
                        bad++;
                        $display("FAIL %s position: got %0d expected %0d", e.name, position, e.pos);
                    end
                    total++;
                    if (line_lost !== e.lost) begin
                        bad++;
                        $display("FAIL %s line_lost: got %0b expected %0b", e.name, line_lost, e.lost);
                    end
                    total++;
                    if (cyc !== e.due) begin
                        bad++;
                        $display("FAIL %s latency: valid at cycle %0d expected %0d", e.name, cyc, e.due);
                    end
                    total++;
                    if (busy_cnt !== e.busy_len) begin
                        bad++;
                        $display("FAIL %s busy_len: got %0d expected %0d", e.name, busy_cnt, e.busy_len);
                    end
                    total++;
                    if (busy !== 1'b0) begin
                        bad++;
                        $display("FAIL %s busy_at_valid: got %0b expected 0", e.name, busy);
                    end
                    $display("conv %s: position=%0d line_lost=%0b cycle=%0d busy_cycles=%0d",
                             e.name, position, line_lost, cyc, busy_cnt);
                end
            end
        end
        if (!seen) begin
            total++; bad++;
            $display("FAIL timeout: no valid within 60 cycles (cycle %0d)", cyc);
            if (sb.size() != 0) void'(sb.pop_front());
        end
    endtask

    task automatic no_valid(input string name, input int n);
        int cnt = 0;
        repeat (n) begin
            @(negedge clk);
            if (valid) cnt++;
        end
        total++;
        if (cnt !== 0) begin
            bad++;
            $display("FAIL %s extra_valid: got %0d pulses expected 0", name, cnt);
        end
        $display("check %s: %0d extra valid pulses in %0d cycles", name, cnt, n);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        channel_sel = 8'h00;
        for (int i = 0; i < 8; i++) ttd_a[i] = '0;
        repeat (3) @(negedge clk);
        total++;
        if ({busy, valid, line_lost} !== 3'b000 || position !== 16'd0) begin
            bad++;
            $display("FAIL reset_state: busy=%0b valid=%0b lost=%0b pos=%0d expected all 0",
                     busy, valid, line_lost, position);
        end
        $display("reset: busy=%0b valid=%0b lost=%0b pos=%0d", busy, valid, line_lost, position);
        reset = 1'b0;
        mpos  = 0;
        @(negedge clk);
    endtask

    task automatic test_single();
        launch("single_ch3", '{0, 0, 0, 10000, 0, 0, 0, 0}, 8'hFF);
        wait_result(1'b0, -1, 1'b0);
        total++;
        if (position !== 16'd3000) begin
            bad++;
            $display("FAIL single_ch3 const: got %0d expected 3000", position);
        end
    endtask

    task automatic test_weighted();
        launch("weighted_2128", '{0, 0, 10000, 4200, 0, 0, 0, 0}, 8'hFF);
        wait_result(1'b0, -1, 1'b1);
        total++;
        if (position !== 16'd2128) begin
            bad++;
            $display("FAIL weighted const: got %0d expected 2128", position);
        end
        launch("weighted_3500", '{0, 0, 0, 8200, 8200, 0, 0, 0}, 8'hFF);
        wait_result(1'b0, -1, 1'b1);
    endtask

    task automatic test_lost();
        launch("lost", '{3000, 3000, 3000, 3000, 3000, 3000, 3000, 3000}, 8'hFF);
        wait_result(1'b0, -1, 1'b0);
        total++;
        if (position !== 16'd3500 || line_lost !== 1'b1) begin
            bad++;
            $display("FAIL lost const: got pos=%0d lost=%0b expected 3500/1", position, line_lost);
        end
    endtask

    task automatic test_mask_and_max();
        launch("mask_0F", '{13200, 0, 0, 0, 0, 0, 0, 131071}, 8'h0F);
        wait_result(1'b0, -1, 1'b0);
        launch("all_max", '{131071, 131071, 131071, 131071, 131071, 131071, 131071, 131071}, 8'hFF);
        wait_result(1'b0, -1, 1'b0);
        total++;
        if (position !== 16'd3500) begin
            bad++;
            $display("FAIL all_max const: got %0d expected 3500", position);
        end
    endtask

    task automatic test_busy_start();
        int launch_cyc;
        launch_cyc = cyc;
        launch("start_while_busy", '{0, 0, 0, 0, 0, 20000, 0, 0}, 8'hFF);
        // negedge cycle e0+4 drives start into edge E5
        wait_result(1'b0, launch_cyc + 5, 1'b0);
        no_valid("start_while_busy", 30);
    endtask

    task automatic test_back_to_back();
        launch("b2b_1", '{0, 9000, 0, 0, 0, 0, 7000, 0}, 8'hFF);
        wait_result(1'b1, -1, 1'b0);
        launch("b2b_2", '{0, 9000, 0, 0, 0, 0, 7000, 0}, 8'hFF);
        wait_result(1'b1, -1, 1'b0);
        launch("b2b_3", '{0, 9000, 0, 0, 0, 0, 7000, 0}, 8'hFF);
        wait_result(1'b1, -1, 1'b0);
        start = 1'b0;
        no_valid("b2b_tail", 30);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 8; i++) ttd_a[i] = '0;
        ttd_a[5]    = 17'd50000;
        channel_sel = 8'hFF;
        start       = 1'b1;
        e0          = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        while (cyc < e0 + 14) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        total++;
        if ({busy, valid, line_lost} !== 3'b000 || position !== 16'd0) begin
            bad++;
            $display("FAIL reset_mid: busy=%0b valid=%0b lost=%0b pos=%0d expected all 0",
                     busy, valid, line_lost, position);
        end
        $display("reset_mid: busy=%0b valid=%0b lost=%0b pos=%0d", busy, valid, line_lost, position);
        reset = 1'b0;
        mpos  = 0;
        no_valid("reset_mid_abort", 30);
        launch("after_reset", '{0, 0, 0, 0, 0, 0, 12000, 5000}, 8'hFF);
        wait_result(1'b0, -1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_single();
        test_weighted();
        test_lost();
        test_mask_and_max();
        test_busy_start();
        test_back_to_back();
        test_reset_mid();
        total++;
        if (sb.size() !== 0) begin
            bad++;
            $display("FAIL scoreboard_drain: %0d entries left expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
